// File: rtl/tdm_demux.sv
// Word-interleaved TDM receiver: deserializes frames into a shadow buffer and publishes them whole.
// Optional per-word even-parity checking is enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_sync,
    input  logic [WIDTH-1:0]          in_data,
`ifdef TDM_DEMUX_PARITY_EN
    input  logic                      in_parity,
`endif
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      out_frame_err
`ifdef TDM_DEMUX_PARITY_EN
    , output logic                    out_parity_err
`endif
);

    localparam int CW = $clog2(CHANNELS);
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t                         state;
    logic [CW-1:0]                  ch;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow;
    logic [CHANNELS-1:0][WIDTH-1:0] frame;
    logic [CHANNELS-1:0][WIDTH-1:0] pub;

`ifdef TDM_DEMUX_PARITY_EN
    logic word_bad;
    logic bad;
    assign word_bad = ^{in_data, in_parity};
`endif

    // Shadow with the current word merged in, so the last word publishes on its own edge.
    always_comb begin
        frame     = shadow;
        frame[ch] = in_data;
    end

    assign out_data = pub;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            ch            <= '0;
            shadow        <= '0;
            pub           <= '0;
            out_valid     <= 1'b0;
            out_frame_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            out_parity_err <= 1'b0;
            bad            <= 1'b0;
`endif
        end else begin
            out_valid     <= 1'b0;
            out_frame_err <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            out_parity_err <= 1'b0;
`endif
            if (in_valid) begin
                if (in_sync) begin
                    // Early sync abandons the partial frame but realigns on this word.
                    if (state == RECV && ch != '0)
                        out_frame_err <= 1'b1;
                    shadow[0] <= in_data;
                    ch        <= CW'(1);
                    state     <= RECV;
`ifdef TDM_DEMUX_PARITY_EN
                    bad       <= word_bad;
`endif
                end else if (state == RECV) begin
                    if (ch == '0) begin
                        out_frame_err <= 1'b1;
                        state         <= HUNT;
                    end else begin
                        shadow[ch] <= in_data;
`ifdef TDM_DEMUX_PARITY_EN
                        bad        <= bad | word_bad;
`endif
                        if (ch == LAST) begin
                            ch <= '0;
`ifdef TDM_DEMUX_PARITY_EN
                            if (bad | word_bad) begin
                                out_parity_err <= 1'b1;
                            end else begin
                                pub       <= frame;
                                out_valid <= 1'b1;
                            end
`else
                            pub       <= frame;
                            out_valid <= 1'b1;
`endif
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receive end of a word-interleaved link, where a multiplexer upstream sends one word per channel in fixed order. The block deserializes each frame into a shadow buffer. It publishes all channels at once when the frame completes, and detects framing loss and resynchronises to the next frame boundary. It sits between the link input register and the per-channel consumers.

## Interface
Parameters:
- WIDTH, 16, data word width in bits (>= 1)
- CHANNELS, 4, words per frame (>= 2); channel counter width = $clog2(CHANNELS)

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high
- in_valid  input  1  in_data/in_sync qualify this cycle
- in_sync  input  1  marks the channel-0 word of a frame
- in_data  input  WIDTH  incoming word
- in_parity  input  1  even-parity bit for in_data (present only with TDM_DEMUX_PARITY_EN)
- out_data  output  CHANNELS*WIDTH  published frame; channel k at bits [k*WIDTH +: WIDTH]
- out_valid  output  1  one-cycle pulse: out_data just updated
- out_frame_err  output  1  one-cycle pulse: framing violation detected
- out_parity_err  output  1  one-cycle pulse: frame dropped for parity (present only with TDM_DEMUX_PARITY_EN)

## Operation
- States: HUNT (no frame alignment), RECV (aligned, counter ch = next expected channel).
- Reset (async, any time including mid-frame): state=HUNT, ch=0, shadow=0, out_data=0, out_valid=0, out_frame_err=0, out_parity_err=0.
- Cycles with in_valid=0: no state change, no outputs pulse. No timeout.
- HUNT:
  - in_valid & ~in_sync: word discarded, no error pulse.
  - in_valid & in_sync: word into shadow[0], ch=1, go RECV.
- RECV, ch=0, in_valid:
  - in_sync=1: word into shadow[0], ch=1.
  - in_sync=0: out_frame_err pulses, word discarded, go HUNT.
- RECV, ch!=0, in_valid:
  - in_sync=0: word into shadow[ch].
    - If ch=CHANNELS-1: shadow (including this word) is copied to out_data, out_valid pulses, ch=0.
    - Otherwise ch=ch+1.
  - in_sync=1 (early sync): out_frame_err pulses. Partial frame abandoned, never published. Word taken as shadow[0], ch=1, stay RECV.
- out_data holds its last published value until the next publish. Shadow contents of abandoned frames never reach out_data.
- Consumers have no backpressure. A frame is published regardless of whether the previous one was read.

## Timing
- All outputs registered.
- Publish latency: out_valid=1 and new out_data visible in the cycle after the edge that accepts the channel CHANNELS-1 word. That is one cycle after the word is presented.
- out_frame_err is asserted in the cycle after the offending word's edge.
- Back-to-back frames with in_valid held high give one out_valid pulse every CHANNELS cycles.
- The ch counter wraps CHANNELS-1 -> 0 only on publish. ch never exceeds CHANNELS-1.

## Configuration
- TDM_DEMUX_PARITY_EN defined:
  - Adds in_parity and out_parity_err.
  - Each accepted word is checked: ^{in_data, in_parity} must be 0. Errors latch a per-frame bad flag, which clears when a channel-0 word is accepted.
  - At the would-be publish edge, a bad frame is not copied: out_data is unchanged, out_valid stays 0, and out_parity_err pulses instead. ch still wraps to 0 and state stays RECV.
  - Discarded words (in HUNT, or on framing error) are not checked.
- TDM_DEMUX_PARITY_EN undefined:
  - Ports in_parity and out_parity_err do not exist.
  - No check is made, and every complete frame publishes.

## Test plan
- Reset, then words 0x0011(sync),0x0022,0x0033,0x0044 on consecutive cycles -> next cycle out_valid=1, out_data=0x0044_0033_0022_0011; all error pulses 0.
- Same frame with in_valid low for 3 cycles between words 2 and 3 -> identical out_data, out_valid exactly one cycle after the 0x0044 word.
- After one good frame, send 0x0055(sync),0x0066, then 0x0077(sync),0x0088,0x0099,0x00AA -> out_frame_err pulse one cycle after 0x0077. Published out_data=0x00AA_0099_0088_0077; 0x0055/0x0066 never appear.
- From HUNT, send 0x1111 (no sync) -> discarded, no pulses. After a good frame, send a non-sync word where sync is expected -> out_frame_err pulse, state HUNT, out_data unchanged.
- Assert reset after 2 words of a frame, then deassert and send a full frame -> out_data=0 until the new publish, then the new frame only.
- With TDM_DEMUX_PARITY_EN: send a frame with bad parity on channel 2 -> out_parity_err pulse, out_valid=0, out_data unchanged. The next clean frame publishes normally.
